// File: rtl/img_stream_arbiter_if.sv
// img_stream_arbiter_if: channel inputs, FIFO-side controls and the shared output port of the stream arbiter.
// The master modport is the arbiter; the slave modport is the channel/FIFO environment.
interface img_stream_arbiter_if #(
  parameter int NCH = 4,
  parameter int DW  = 32,
  parameter int MW  = 2,
  parameter int SW  = $clog2(NCH)
);
  logic [NCH*MW-1:0] slv_mode;
  logic [NCH-1:0]    slv_data_valid;
  logic [NCH-1:0]    slv_proc_valid;
  logic [NCH*DW-1:0] slv_data;
  logic [NCH-1:0]    slv_ready;
  logic              fifo_full;
  logic              mstr_cmplt;
  logic [MW-1:0]     slvx_mode;
  logic              slvx_data_valid;
  logic              slvx_proc_val;
  logic [DW-1:0]     slvx_data;
  logic [SW-1:0]     data_source;
  modport master (
    input  slv_mode, slv_data_valid, slv_proc_valid, slv_data, fifo_full, mstr_cmplt,
    output slv_ready, slvx_mode, slvx_data_valid, slvx_proc_val, slvx_data, data_source
  );
  modport slave (
    output slv_mode, slv_data_valid, slv_proc_valid, slv_data, fifo_full, mstr_cmplt,
    input  slv_ready, slvx_mode, slvx_data_valid, slvx_proc_val, slvx_data, data_source
  );
endinterface

// File: rtl/img_stream_arbiter.sv
// img_stream_arbiter: N-channel round-robin stream arbiter with bounded bursts, fifo_full backpressure and flush.
// Define ARB_STRICT_PRIO_EN to pick the lowest-index requester instead of round-robin.
module img_stream_arbiter #(
  parameter int NCH   = 4,
  parameter int DW    = 32,
  parameter int MW    = 2,
  parameter int BURST = 16
) (
  input logic clk,
  input logic rst_n,
  img_stream_arbiter_if.master bus
);
  localparam int SW = $clog2(NCH);
  localparam int CW = $clog2(BURST + 1);
  typedef enum logic [1:0] {IDLE, GRANT, FLUSH} state_t;
  state_t state, state_d;
  logic [SW-1:0] owner, pick, idx, src;
  logic [CW-1:0] beat_cnt;
  logic [NCH-1:0] req;
  logic any_req, acc, last, grab, rel, flush, vld, pvl;
  logic [MW-1:0] mode;
  logic [DW-1:0] data;
  for (genvar i = 0; i < NCH; i++) begin : g_req
    assign req[i] = |bus.slv_mode[i*MW +: MW];
  end
  assign any_req = |req;
  assign flush = bus.mstr_cmplt || state == FLUSH;
  assign bus.slv_ready = (state == GRANT && !bus.fifo_full && !bus.mstr_cmplt) ? NCH'(1) << owner : '0;
  assign acc = bus.slv_ready[owner] & bus.slv_data_valid[owner];
  assign last = acc && beat_cnt == CW'(BURST - 1);
  // scanning from the far end lets the nearest requester overwrite earlier matches
`ifdef ARB_STRICT_PRIO_EN
  always_comb begin
    pick = '0;
    idx = '0;
    for (int k = NCH - 1; k >= 0; k--) begin
      idx = SW'(k);
      pick = req[idx] ? idx : pick;
    end
  end
`else
  logic [SW-1:0] rr_ptr;
  always_comb begin
    pick = '0;
    idx = '0;
    for (int k = NCH - 1; k >= 0; k--) begin
      idx = SW'((int'(rr_ptr) + k) % NCH);
      pick = req[idx] ? idx : pick;
    end
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) rr_ptr <= '0;
    else if (flush) rr_ptr <= '0;
    else if (rel) rr_ptr <= owner == SW'(NCH - 1) ? '0 : owner + 1'b1;
`endif
  always_comb begin
    state_d = state;
    grab = 1'b0;
    rel = 1'b0;
    if (bus.mstr_cmplt) state_d = FLUSH;
    else case (state)
      IDLE: begin
        grab = any_req;
        state_d = any_req ? GRANT : IDLE;
      end
      GRANT: begin
        rel = last || !req[owner];
        state_d = rel ? IDLE : GRANT;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_d;
  // the accepted beat is registered even when the grant is released in the same cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      owner <= '0;
      src <= '0;
      beat_cnt <= '0;
      vld <= 1'b0;
      pvl <= 1'b0;
      mode <= '0;
      data <= '0;
    end else if (flush) begin
      src <= '0;
      vld <= 1'b0;
      pvl <= 1'b0;
      mode <= '0;
      data <= '0;
    end else begin
      vld <= acc;
      if (acc) begin
        data <= bus.slv_data[int'(owner)*DW +: DW];
        mode <= bus.slv_mode[int'(owner)*MW +: MW];
        pvl <= bus.slv_proc_valid[owner];
        beat_cnt <= beat_cnt + 1'b1;
      end
      if (grab) begin
        owner <= pick;
        src <= pick;
        beat_cnt <= '0;
      end
    end
  end
  assign bus.slvx_data_valid = vld;
  assign bus.slvx_proc_val = pvl;
  assign bus.slvx_mode = mode;
  assign bus.slvx_data = data;
  assign bus.data_source = src;
endmodule

// File: tb/tb_img_stream_arbiter.sv
// tb_img_stream_arbiter: scenario tasks plus randomized traffic, checked against a cycle-level behavioural model.
module tb_img_stream_arbiter;
  localparam int NCH = 4, DW = 32, MW = 2, BURST = 4, SW = $clog2(NCH);
  localparam int OW = 1 + MW + 1 + DW + SW;
  logic clk = 1'b0, rst_n = 1'b0;
  always #5 clk = ~clk;
  img_stream_arbiter_if #(.NCH(NCH), .DW(DW), .MW(MW)) bus ();
  img_stream_arbiter #(.NCH(NCH), .DW(DW), .MW(MW), .BURST(BURST)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  int n_vec = 0, n_err = 0;
  int m_own, m_used, m_ptr;
  bit m_flush;
  logic e_v, e_p;
  logic [MW-1:0] e_m;
  logic [DW-1:0] e_d;
  logic [SW-1:0] e_src;
  logic [NCH-1:0] rdy_obs, rdy_exp;
  wire [OW-1:0] obs = {bus.slvx_data_valid, bus.slvx_mode, bus.slvx_proc_val, bus.slvx_data, bus.data_source};
  wire [OW-1:0] exp_out = {e_v, e_m, e_p, e_d, e_src};

  task automatic m_reset();
    m_own = -1; m_used = 0; m_ptr = 0; m_flush = 0;
    e_v = 0; e_p = 0; e_m = '0; e_d = '0; e_src = '0;
  endtask

  function automatic int chosen();
`ifdef ARB_STRICT_PRIO_EN
    for (int k = 0; k < NCH; k++) if (bus.slv_mode[k*MW +: MW] != 0) return k;
`else
    for (int d = 0; d < NCH; d++) if (bus.slv_mode[((m_ptr + d) % NCH)*MW +: MW] != 0) return (m_ptr + d) % NCH;
`endif
    return -1;
  endfunction

  task automatic model();
    int c;
    bit acc;
    if (bus.mstr_cmplt) begin
      m_flush = 1; m_own = -1; m_ptr = 0;
      e_v = 0; e_p = 0; e_m = '0; e_d = '0; e_src = '0;
    end else if (m_flush) m_flush = 0;
    else if (m_own < 0) begin
      e_v = 0;
      c = chosen();
      if (c >= 0) begin m_own = c; m_used = 0; e_src = SW'(c); end
    end else begin
      acc = !bus.fifo_full && bus.slv_data_valid[m_own];
      e_v = acc;
      if (acc) begin
        e_d = bus.slv_data[m_own*DW +: DW];
        e_m = bus.slv_mode[m_own*MW +: MW];
        e_p = bus.slv_proc_valid[m_own];
        m_used++;
      end
      if ((acc && m_used == BURST) || bus.slv_mode[m_own*MW +: MW] == 0) begin
        m_ptr = (m_own + 1) % NCH;
        m_own = -1;
      end
    end
  endtask

  task automatic step();
    @(negedge clk);
    rdy_obs = bus.slv_ready;
    rdy_exp = (m_own >= 0 && !bus.fifo_full && !bus.mstr_cmplt) ? NCH'(1) << m_own : '0;
    model();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ch(input int c, input int md, input bit v, input logic [DW-1:0] d);
    bus.slv_mode[c*MW +: MW] = MW'(md);
    bus.slv_data_valid[c] = v;
    bus.slv_proc_valid[c] = ^d;
    bus.slv_data[c*DW +: DW] = d;
  endtask

  task automatic clear_inputs();
    bus.slv_mode = '0; bus.slv_data_valid = '0; bus.slv_proc_valid = '0;
    bus.slv_data = '0; bus.fifo_full = 0; bus.mstr_cmplt = 0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst_n = 0;
    @(posedge clk);
    #1;
    rst_n = 1;
    m_reset();
  endtask

  function automatic int idx_of(input logic [NCH-1:0] v);
    for (int k = 0; k < NCH; k++) if (v[k]) return k;
    return -1;
  endfunction

  task automatic test_reset();
    clear_inputs();
    set_ch(1, 1, 1, 32'h55);
    rst_n = 0;
    repeat (2) @(posedge clk);
    #1;
    n_vec++;
    if (obs !== '0 || bus.slv_ready !== '0) begin
      n_err++; $display("FAIL reset: out=%h ready=%b, expected 0/0", obs, bus.slv_ready);
    end
    clear_inputs();
    rst_n = 1;
    m_reset();
    step();
    n_vec++;
    if (rdy_obs !== '0 || obs !== '0) begin
      n_err++; $display("FAIL reset_idle: ready=%b out=%h, expected 0/0", rdy_obs, obs);
    end
  endtask

  task automatic test_single();
    int n_in = 0, n_out = 0;
    logic [NCH-1:0] want;
    do_reset();
    set_ch(1, 1, 1, 32'h100);
    for (int i = 0; i < 3 * (BURST + 1) + 1; i++) begin
      step();
      want = (i % (BURST + 1) == 0) ? '0 : 4'b0010;
      n_vec++;
      if (rdy_obs !== want || rdy_obs !== rdy_exp || obs !== exp_out) begin
        n_err++; $display("FAIL single cyc %0d: ready=%b out=%h, expected ready=%b out=%h", i, rdy_obs, obs, want, exp_out);
      end
      if (bus.slvx_data_valid) begin
        n_vec++;
        if (bus.slvx_data !== 32'h100 + n_out || bus.data_source !== 1) begin
          n_err++; $display("FAIL single_beat %0d: data=%h src=%0d, expected %h/1", n_out, bus.slvx_data, bus.data_source, 32'h100 + n_out);
        end
        n_out++;
      end
      if (rdy_obs[1]) n_in++;
      set_ch(1, 1, 1, 32'h100 + n_in);
    end
    n_vec++;
    if (n_out != 3 * BURST) begin
      n_err++; $display("FAIL single_count: beats=%0d, expected %0d", n_out, 3 * BURST);
    end
  endtask

  task automatic test_round_robin();
    int order[$], runs[$];
    int run = 0;
    logic [NCH-1:0] prev = '0;
    do_reset();
    for (int i = 0; i < 4 * (BURST + 1) + 1; i++) begin
      set_ch(0, 1, 1, $urandom); set_ch(2, 2, 1, $urandom); set_ch(3, 3, 1, $urandom);
      step();
      n_vec++;
      if (!$onehot0(rdy_obs) || rdy_obs !== rdy_exp || obs !== exp_out) begin
        n_err++; $display("FAIL rr cyc %0d: ready=%b out=%h, expected ready=%b out=%h", i, rdy_obs, obs, rdy_exp, exp_out);
      end
      if (rdy_obs != 0 && prev == 0) order.push_back(idx_of(rdy_obs));
      if (rdy_obs != 0) run++;
      else if (prev != 0) begin runs.push_back(run); run = 0; end
      prev = rdy_obs;
    end
    n_vec++;
    if (order.size() < 4 || order[0] != 0 || order[1] != 2 || order[2] != 3 || order[3] != 0) begin
      n_err++; $display("FAIL rr_order: got %0d grants starting %0d,%0d,%0d,%0d, expected 0,2,3,0", order.size(), order[0], order[1], order[2], order[3]);
    end
    n_vec++;
    if (runs.size() < 3 || runs[0] != BURST || runs[1] != BURST || runs[2] != BURST) begin
      n_err++; $display("FAIL rr_burst: runs %0d,%0d,%0d, expected %0d each", runs[0], runs[1], runs[2], BURST);
    end
  endtask

  task automatic test_backpressure();
    int n_in = 0;
    logic [DW-1:0] q[$];
    logic [NCH-1:0] want;
    do_reset();
    set_ch(2, 1, 1, 32'h200);
    for (int i = 0; i < 14; i++) begin
      step();
      want = (i == 0 || i == BURST + 6 || (i >= 3 && i <= 7)) ? '0 : 4'b0100;
      n_vec++;
      if (rdy_obs !== want || rdy_obs !== rdy_exp || obs !== exp_out || (bus.fifo_full && bus.slvx_data_valid) || bus.data_source !== 2) begin
        n_err++; $display("FAIL backpressure cyc %0d: ready=%b out=%h, expected ready=%b out=%h", i, rdy_obs, obs, want, exp_out);
      end
      if (bus.slvx_data_valid) q.push_back(bus.slvx_data);
      if (rdy_obs[2]) n_in++;
      bus.fifo_full = i >= 2 && i < 7;
      set_ch(2, 1, 1, 32'h200 + n_in);
    end
    n_vec++;
    if (q.size() < BURST) begin
      n_err++; $display("FAIL backpressure_count: beats=%0d, expected at least %0d", q.size(), BURST);
    end
    foreach (q[k]) begin
      n_vec++;
      if (q[k] !== 32'h200 + k) begin
        n_err++; $display("FAIL backpressure_seq %0d: data=%h, expected %h", k, q[k], 32'h200 + k);
      end
    end
  endtask

  task automatic test_mode_drop();
    int n_in = 0, t = 0;
    do_reset();
    set_ch(1, 1, 1, $urandom); set_ch(3, 1, 1, $urandom);
    while (n_in < 3 && t < 20) begin
      step();
      n_vec++;
      if (rdy_obs !== rdy_exp || obs !== exp_out) begin
        n_err++; $display("FAIL mode_drop cyc %0d: ready=%b out=%h, expected ready=%b out=%h", t, rdy_obs, obs, rdy_exp, exp_out);
      end
      if (rdy_obs[1]) n_in++;
      t++;
    end
    n_vec++;
    if (n_in < 3) begin
      n_err++; $display("FAIL mode_drop_timeout: beats=%0d, expected 3", n_in);
    end
    set_ch(1, 0, 0, 0);
    for (int j = 0; j < 3; j++) begin
      step();
      n_vec++;
      if (rdy_obs !== rdy_exp || obs !== exp_out || (j == 1 && (rdy_obs !== '0 || bus.data_source !== 3)) || (j == 2 && rdy_obs !== 4'b1000)) begin
        n_err++; $display("FAIL mode_drop_release %0d: ready=%b src=%0d out=%h, expected ready=%b out=%h", j, rdy_obs, bus.data_source, obs, rdy_exp, exp_out);
      end
    end
  endtask

  task automatic test_flush();
    int n_in = 0, t = 0;
    logic [NCH-1:0] want;
    do_reset();
    set_ch(0, 1, 1, $urandom); set_ch(2, 1, 1, $urandom);
    while (n_in < 2 && t < 30) begin
      step();
      n_vec++;
      if (rdy_obs !== rdy_exp || obs !== exp_out) begin
        n_err++; $display("FAIL flush_pre cyc %0d: ready=%b out=%h, expected ready=%b out=%h", t, rdy_obs, obs, rdy_exp, exp_out);
      end
      if (rdy_obs[2]) n_in++;
      t++;
    end
    n_vec++;
    if (n_in < 2) begin
      n_err++; $display("FAIL flush_timeout: ch2 beats=%0d, expected 2", n_in);
    end
    bus.mstr_cmplt = 1;
    for (int j = 0; j < 6; j++) begin
      step();
      want = (j == 5) ? 4'b0001 : '0;
      n_vec++;
      if (rdy_obs !== want || rdy_obs !== rdy_exp || obs !== exp_out || (j < 5 && obs !== '0)) begin
        n_err++; $display("FAIL flush %0d: ready=%b out=%h, expected ready=%b out=%h", j, rdy_obs, obs, want, exp_out);
      end
      bus.mstr_cmplt = j < 2;
    end
  endtask

  task automatic test_prio();
    bit saw3 = 0;
    do_reset();
    set_ch(0, 1, 1, $urandom); set_ch(3, 1, 1, $urandom);
    for (int i = 0; i < 3 * (BURST + 1) + 1; i++) begin
      step();
      n_vec++;
      if (rdy_obs !== rdy_exp || obs !== exp_out) begin
        n_err++; $display("FAIL prio cyc %0d: ready=%b out=%h, expected ready=%b out=%h", i, rdy_obs, obs, rdy_exp, exp_out);
      end
      if (rdy_obs[3]) saw3 = 1;
    end
    n_vec++;
`ifdef ARB_STRICT_PRIO_EN
    if (saw3) begin n_err++; $display("FAIL prio_starve: ch3 granted=1, expected 0"); end
`else
    if (!saw3) begin n_err++; $display("FAIL prio_rr: ch3 granted=0, expected 1"); end
`endif
  endtask

  task automatic test_reset_mid();
    do_reset();
    set_ch(1, 2, 1, $urandom);
    repeat (3) step();
    #2 rst_n = 0;
    #1;
    n_vec++;
    if (obs !== '0 || bus.slv_ready !== '0) begin
      n_err++; $display("FAIL reset_mid: out=%h ready=%b, expected 0/0", obs, bus.slv_ready);
    end
    @(posedge clk);
    #1;
    rst_n = 1;
    m_reset();
    for (int i = 0; i < 4; i++) begin
      step();
      n_vec++;
      if (rdy_obs !== rdy_exp || obs !== exp_out) begin
        n_err++; $display("FAIL reset_mid_resume %0d: ready=%b out=%h, expected ready=%b out=%h", i, rdy_obs, obs, rdy_exp, exp_out);
      end
    end
  endtask

  task automatic test_random();
    int md[NCH];
    do_reset();
    for (int i = 0; i < 800; i++) begin
      for (int c = 0; c < NCH; c++) begin
        if ($urandom_range(9) == 0) md[c] = int'($urandom_range(3));
        set_ch(c, md[c], $urandom_range(3) != 0, $urandom);
      end
      bus.fifo_full = $urandom_range(4) == 0;
      bus.mstr_cmplt = $urandom_range(40) == 0;
      step();
      n_vec++;
      if (!$onehot0(rdy_obs) || rdy_obs !== rdy_exp || obs !== exp_out) begin
        n_err++; $display("FAIL random cyc %0d: ready=%b out=%h, expected ready=%b out=%h", i, rdy_obs, obs, rdy_exp, exp_out);
      end
    end
  endtask

  initial begin
    m_reset();
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_mode_drop();
    test_flush();
    test_prio();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end
endmodule

// File: doc/img_stream_arbiter.md
Name: img_stream_arbiter

Overview:
Parametrised N-channel stream arbiter for the image-processing datapath. It grants one slave channel at a time to the shared output port, which feeds the downstream pixel FIFO. Arbitration is round-robin with a bounded burst length. It honours fifo_full backpressure and a master-complete flush. It replaces the fixed two-slave arbiter and adds burst fairness, an explicit FSM and a single-cycle registered datapath.

Parameters:
NCH, 4, number of slave channels (>=2)
DW, 32, data width per channel
MW, 2, mode field width; mode==0 means channel inactive
BURST, 16, max accepted beats per grant before forced re-arbitration (>=1)
SW, $clog2(NCH), source-index width (derived, not overridden)

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
slv_mode  in  NCH*MW  per-channel mode, channel i at [i*MW +: MW]
slv_data_valid  in  NCH  per-channel beat valid
slv_proc_valid  in  NCH  per-channel processing-valid sideband
slv_data  in  NCH*DW  per-channel data, channel i at [i*DW +: DW]
slv_ready  out  NCH  per-channel ready, one-hot or zero
fifo_full  in  1  downstream FIFO full
mstr_cmplt  in  1  master frame complete; forces flush
slvx_mode  out  MW  mode of the last accepted beat
slvx_data_valid  out  1  output beat valid, one cycle per accepted beat
slvx_proc_val  out  1  proc_valid of the accepted beat
slvx_data  out  DW  accepted beat data
data_source  out  SW  index of the currently granted channel

Behaviour:
- Clock and reset: one clock, clk. rst_n is asynchronous and active-low. All state resets asynchronously.
- Reset values: every output 0, state IDLE, rr_ptr 0, beat_cnt 0, owner 0.
- Request: req[i] = (slv_mode[i] != 0).
- FSM states: IDLE, GRANT, FLUSH.
- IDLE:
  - If mstr_cmplt, go to FLUSH.
  - Else if any req: owner <= first requesting index at or after rr_ptr (wrapping modulo NCH), beat_cnt <= 0, data_source <= owner, go to GRANT.
  - Choosing an owner takes 1 cycle; no ready is asserted in IDLE.
- GRANT:
  - slv_ready[owner] = ~fifo_full & ~mstr_cmplt. This is combinational from state/owner and the inputs. All other ready bits are 0.
  - Accept when slv_ready[owner] & slv_data_valid[owner].
  - On accept, next cycle: slvx_data_valid=1; slvx_data, slvx_mode and slvx_proc_val take the owner's values; beat_cnt increments.
  - When no accept occurs, slvx_data_valid=0 next cycle. slvx_data, slvx_mode and slvx_proc_val hold their last values.
- Release from GRANT to IDLE, with rr_ptr <= owner+1 (wrapping), on any of:
  - beat_cnt reaches BURST on an accept, i.e. the last beat is accepted;
  - slv_mode[owner] == 0;
  - mstr_cmplt (goes to FLUSH instead of IDLE).
- Backpressure: fifo_full drops ready in the same cycle. No beat is accepted while fifo_full=1. The grant and beat_cnt hold; there is no re-arbitration while full.
- Simultaneous accept and release: the accepted beat is still presented next cycle. Release takes effect after it.
- FLUSH:
  - All ready bits 0, slvx_data_valid 0, slvx_mode 0, slvx_proc_val 0, data_source 0, rr_ptr 0.
  - Stay in FLUSH while mstr_cmplt=1, then go to IDLE.
  - mstr_cmplt has priority over every other condition, in every state.
- Single requester: that requester re-wins after each release, costing one IDLE bubble cycle per BURST beats.
- No requesters: remain in IDLE with all outputs idle.
- Reset mid-burst: everything returns to reset values immediately. A beat that was in flight is dropped.

Optional Feature:
ARB_STRICT_PRIO_EN
- Defined: IDLE selects the lowest-index requester regardless of rr_ptr, and rr_ptr is unused.
- Defined: the BURST limit still applies, so after BURST beats channel 0 may immediately re-win.
- Undefined: round-robin as specified above.

Test Plan:
1. Reset, then ch1 mode=1 with valid held high, data=0x100+n → IDLE 1 cycle, then slv_ready=4'b0010, data_source=1, output beats 0x100.. with 1-cycle latency. 16 beats, then 1 bubble, then ch1 re-granted.
2. ch0, ch2 and ch3 all requesting with BURST=4 → grant order 0,2,3,0; each grant exactly 4 beats; slv_ready always one-hot.
3. ch2 granted; fifo_full=1 for 5 cycles after beat 2 → slv_ready=0 and slvx_data_valid=0 during those cycles. beat_cnt stays 2, grant stays 2, and the burst resumes after full clears. 16 total beats, none duplicated.
4. ch1 drops mode to 0 after beat 3 while ch3 is requesting → ch1 released, 1 IDLE cycle, then data_source=3.
5. mstr_cmplt pulsed for 3 cycles mid-burst → all outputs 0 within 1 cycle, FLUSH held for 3 cycles, rr_ptr=0, then ch0 wins if requesting.
6. With ARB_STRICT_PRIO_EN defined and ch0 and ch3 requesting continuously → ch3 is never granted; ch0 gets bursts of BURST beats separated by 1 bubble.
